// File: rtl/memory_access_unit.sv
// Memory access unit: accepts fetch/load/store requests from the control unit and
// runs one word-addressed, byte-selected bus transaction with lane steering and extension.
package memory_access_unit_pkg;
  typedef enum logic [1:0] {MEM_NONE, FETCH_DATA, LOAD_DATA, STORE_DATA} memory_operation_t;
endpackage

module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  memory_operation_t memory_operation,
  input  logic              cyc,
  input  logic [2:0]        funct3,
  input  logic [31:0]       pc,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              ack,
  output logic              done,
  output logic              data_valid,
  output logic              err,
  output logic [31:0]       fetched_data,
  output logic              mem_cyc,
  output logic              mem_stb,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [31:0]       mem_adr,
  output logic [31:0]       mem_dat_o,
  input  logic [31:0]       mem_dat_i,
  input  logic              mem_ack,
  input  logic              mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic [CW-1:0] r_cnt;
  logic        r_ack, r_done, r_dv, r_err, r_cyc, r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr, r_dato, r_data;

  logic        w_fetch, w_store, w_accept, w_bad;
  logic [31:0] w_a, w_dato, w_load;
  logic [1:0]  w_size;
  logic [3:0]  w_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_fetch  = (memory_operation == FETCH_DATA);
    w_store  = (memory_operation == STORE_DATA);
    w_accept = cyc && (memory_operation != MEM_NONE);
    w_a      = w_fetch ? pc : addr;
    w_size   = w_fetch ? 2'b10 : funct3[1:0];
    w_bad    = 1'b0;
    if (!w_fetch) begin
      if (funct3[1:0] == 2'b11)            w_bad = 1'b1;
      if (funct3[2] && funct3[1])          w_bad = 1'b1;
      if (w_store && funct3[2])            w_bad = 1'b1;
    end
    if (w_size == 2'b01 && w_a[0])         w_bad = 1'b1;
    if (w_size == 2'b10 && (|w_a[1:0]))    w_bad = 1'b1;
    case (w_size)
      2'b00:   begin w_sel = 4'b0001 << w_a[1:0]; w_dato = {4{store_data[7:0]}};  end
      2'b01:   begin w_sel = 4'b0011 << w_a[1:0]; w_dato = {2{store_data[15:0]}}; end
      default: begin w_sel = 4'b1111;             w_dato = store_data;            end
    endcase
  end

  // Fetches latch funct3 as 3'b010 so the load path returns the whole word.
  always_comb begin
    case (r_lo)
      2'b00:   w_byte = mem_dat_i[7:0];
      2'b01:   w_byte = mem_dat_i[15:8];
      2'b10:   w_byte = mem_dat_i[23:16];
      default: w_byte = mem_dat_i[31:24];
    endcase
    w_half = r_lo[1] ? mem_dat_i[31:16] : mem_dat_i[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'b0, w_byte};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = mem_dat_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f3    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
      r_dv    <= 1'b0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dato  <= '0;
      r_data  <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_BUS: begin
          if (mem_err || mem_ack || r_cnt == CW'(TIMEOUT - 1)) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= S_RESP;
            if (mem_ack && !mem_err) begin
              r_done <= 1'b1;
              if (!r_we) begin
                r_data <= w_load;
                r_dv   <= 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          // Holding off while ack is still high keeps a two-cycle cyc from re-accepting.
          if (w_accept && !r_ack) begin
            r_ack  <= 1'b1;
            r_done <= 1'b0;
            r_dv   <= 1'b0;
            r_f3   <= w_fetch ? 3'b010 : funct3;
            r_lo   <= w_a[1:0];
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err   <= 1'b0;
              r_cyc   <= 1'b1;
              r_we    <= w_store;
              r_sel   <= w_sel;
              r_adr   <= {w_a[31:2], 2'b00};
              r_dato  <= w_dato;
              r_cnt   <= '0;
              r_state <= S_BUS;
            end
          end
        end
      endcase
    end
  end

  assign ack          = r_ack;
  assign done         = r_done;
  assign data_valid   = r_dv;
  assign err          = r_err;
  assign fetched_data = r_data;
  assign mem_cyc      = r_cyc;
  assign mem_stb      = r_cyc;
  assign mem_we       = r_we;
  assign mem_sel      = r_sel;
  assign mem_adr      = r_adr;
  assign mem_dat_o    = r_dato;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit (TIMEOUT overridden to 4).
module tb_memory_access_unit;
  import memory_access_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  memory_operation_t memory_operation = MEM_NONE;
  logic cyc = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] pc = '0, addr = '0, store_data = '0, mem_dat_i = '0;
  logic ack, done, data_valid, err, mem_cyc, mem_stb, mem_we, mem_ack, mem_err;
  logic [31:0] fetched_data, mem_adr, mem_dat_o;
  logic [3:0]  mem_sel;
  logic zw = 1'b0, man_ack = 1'b0, man_err = 1'b0;
  int tests = 0, fails = 0;
  int stb_cnt = 0, ack_cnt = 0;
  int stb_base, ack_base;

  memory_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .memory_operation(memory_operation), .cyc(cyc),
    .funct3(funct3), .pc(pc), .addr(addr), .store_data(store_data),
    .ack(ack), .done(done), .data_valid(data_valid), .err(err),
    .fetched_data(fetched_data), .mem_cyc(mem_cyc), .mem_stb(mem_stb),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_adr(mem_adr), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_ack = (zw && mem_stb) || man_ack;
    mem_err = man_err;
  end

  always @(posedge clk) begin
    if (mem_stb) stb_cnt <= stb_cnt + 1;
    if (ack)     ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one edge and returns at the negedge after acceptance.
  task automatic issue(input memory_operation_t op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    memory_operation = op; funct3 = f3; pc = a; addr = a; store_data = sd; cyc = 1'b1;
    @(negedge clk);
    cyc = 1'b0; memory_operation = MEM_NONE;
  endtask

  task automatic load_zw(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [3:0] sel, input logic [31:0] res);
    issue(LOAD_DATA, f3, a, 32'h0);
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    chk({tag, "_dv_clr"}, {31'b0, data_valid}, 32'd0);
    chk({tag, "_sel"}, {28'b0, mem_sel}, {28'b0, sel});
    @(negedge clk);
    chk({tag, "_data"}, fetched_data, res);
    chk({tag, "_dv"}, {31'b0, data_valid}, 32'd1);
  endtask

  task automatic precheck(input string tag, input memory_operation_t op,
                          input logic [2:0] f3, input logic [31:0] a);
    stb_base = stb_cnt;
    issue(op, f3, a, 32'hDEADBEEF);
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    chk({tag, "_err"}, {31'b0, err}, 32'd1);
    chk({tag, "_cyc"}, {31'b0, mem_cyc}, 32'd0);
    @(negedge clk);
    chk({tag, "_nostb"}, stb_cnt - stb_base, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_ack",  {31'b0, ack}, 32'd0);
    chk("rst_stat", {29'b0, done, data_valid, err}, 32'd0);
    chk("rst_bus",  {29'b0, mem_cyc, mem_stb, mem_we}, 32'd0);
    chk("rst_sel",  {28'b0, mem_sel}, 32'd0);
    chk("rst_adr",  mem_adr, 32'd0);
    chk("rst_dato", mem_dat_o, 32'd0);
    chk("rst_data", fetched_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    zw = 1'b1; mem_dat_i = 32'h00500093;
    stb_base = stb_cnt;
    issue(FETCH_DATA, 3'b111, 32'h100, 32'h0);
    chk("f_ack", {31'b0, ack}, 32'd1);
    chk("f_stb", {31'b0, mem_stb}, 32'd1);
    chk("f_sel", {28'b0, mem_sel}, 32'hF);
    chk("f_adr", mem_adr, 32'h100);
    chk("f_we",  {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    chk("f_ackoff", {31'b0, ack}, 32'd0);
    chk("f_data", fetched_data, 32'h00500093);
    chk("f_dvdone", {30'b0, data_valid, done}, 32'd3);
    @(negedge clk);
    chk("f_onestb", stb_cnt - stb_base, 32'd1);
    chk("f_hold", {30'b0, data_valid, done}, 32'd3);

    mem_dat_i = 32'h80FF7F01;
    load_zw("lb",  3'b000, 32'h203, 4'b1000, 32'hFFFFFF80);
    load_zw("lbu", 3'b100, 32'h203, 4'b1000, 32'h00000080);
    load_zw("lh",  3'b001, 32'h202, 4'b1100, 32'hFFFF80FF);
    load_zw("lhu", 3'b101, 32'h202, 4'b1100, 32'h000080FF);

    issue(STORE_DATA, 3'b000, 32'h301, 32'h12345678);
    chk("sb_sel",  {28'b0, mem_sel}, 32'b0010);
    chk("sb_dato", mem_dat_o, 32'h78787878);
    chk("sb_we",   {31'b0, mem_we}, 32'd1);
    chk("sb_adr",  mem_adr, 32'h300);
    @(negedge clk);
    chk("sb_done", {30'b0, done, data_valid}, 32'b10);
    issue(STORE_DATA, 3'b001, 32'h302, 32'h12345678);
    chk("sh_sel",  {28'b0, mem_sel}, 32'b1100);
    chk("sh_dato", mem_dat_o, 32'h56785678);
    @(negedge clk);
    chk("sh_done", {30'b0, done, data_valid}, 32'b10);

    precheck("lw_mis", LOAD_DATA, 3'b010, 32'h202);
    precheck("sh_mis", STORE_DATA, 3'b001, 32'h301);
    precheck("f_mis",  FETCH_DATA, 3'b000, 32'h102);
    precheck("f3_011", LOAD_DATA, 3'b011, 32'h200);
    precheck("sbu",    STORE_DATA, 3'b100, 32'h200);

    zw = 1'b0;
    issue(LOAD_DATA, 3'b010, 32'h200, 32'h0);
    chk("be_errclr", {31'b0, err}, 32'd0);
    @(negedge clk); @(negedge clk);
    man_err = 1'b1;
    @(negedge clk); man_err = 1'b0;
    chk("be_err", {31'b0, err}, 32'd1);
    chk("be_done", {30'b0, done, data_valid}, 32'd0);
    chk("be_cyc", {31'b0, mem_cyc}, 32'd0);

    stb_base = stb_cnt;
    issue(LOAD_DATA, 3'b010, 32'h200, 32'h0);
    repeat (3) @(negedge clk);
    chk("to_early", {30'b0, err, mem_stb}, 32'b01);
    @(negedge clk);
    chk("to_err", {30'b0, err, mem_cyc}, 32'b10);
    chk("to_cycles", stb_cnt - stb_base, 32'd4);

    issue(LOAD_DATA, 3'b010, 32'h200, 32'h0);
    repeat (3) @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk); man_ack = 1'b0;
    chk("to_ackwins", {30'b0, done, err}, 32'b10);
    chk("to_ackdata", fetched_data, 32'h80FF7F01);

    issue(LOAD_DATA, 3'b010, 32'h200, 32'h0);
    man_ack = 1'b1; man_err = 1'b1;
    @(negedge clk); man_ack = 1'b0; man_err = 1'b0;
    chk("ae_err", {30'b0, done, err}, 32'b01);

    issue(LOAD_DATA, 3'b010, 32'h200, 32'h0);
    chk("rb_stb", {31'b0, mem_stb}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rb_stb0", {30'b0, mem_cyc, mem_stb}, 32'd0);
    chk("rb_stat", {28'b0, ack, done, data_valid, err}, 32'd0);
    man_ack = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rb_late", {29'b0, done, data_valid, err}, 32'd0);
    man_ack = 1'b0;

    zw = 1'b1; mem_dat_i = 32'hCAFEF00D;
    ack_base = ack_cnt;
    @(negedge clk);
    memory_operation = FETCH_DATA; pc = 32'h400; cyc = 1'b1;
    @(negedge clk); @(negedge clk);
    cyc = 1'b0; memory_operation = MEM_NONE;
    repeat (3) @(negedge clk);
    chk("hold_once", ack_cnt - ack_base, 32'd1);
    chk("hold_data", fetched_data, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
